// File: rtl/avaliador_ativos.sv
// Active-node table for a shortest-path search: keeps NUM_NA candidate nodes, applies
// distance relaxations and, on request, approves every node whose distance is within the threshold.
module avaliador_ativos #(
   parameter int ADDR_WIDTH      = 10,
   parameter int DISTANCIA_WIDTH = 6,
   parameter int CUSTO_WIDTH     = 4,
   parameter int NUM_NA          = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            lvv_atualizar_in,
   input  logic [ADDR_WIDTH-1:0]           lvv_endereco_in,
   input  logic [DISTANCIA_WIDTH-1:0]      lvv_distancia_in,
   input  logic [ADDR_WIDTH-1:0]           lvv_anterior_in,
   input  logic [CUSTO_WIDTH-1:0]          lvv_menor_vizinho_in,
   input  logic                            lvv_desativar_in,
   input  logic [ADDR_WIDTH-1:0]           lvv_desativar_addr_in,
   input  logic                            cme_avaliar_in,
   output logic                            aa_ocupado_out,
   output logic                            aa_pronto_out,
   output logic [NUM_NA-1:0]               aa_aprovado_out,
   output logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_out,
   output logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_out,
   output logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out,
   output logic                            aa_vazio_out,
   output logic                            aa_cheio_out,
   output logic                            aa_overflow_out
);

   localparam int SW   = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
   localparam int SUMW = DISTANCIA_WIDTH + 1;

   typedef enum logic [2:0] {IDLE, DESATIVAR, ATUALIZAR, LIMIAR, MARCAR, PRONTO} estado_t;

   estado_t                    estado_q, estado_d;
   logic [NUM_NA-1:0]          valid_q, valid_d;
   logic [ADDR_WIDTH-1:0]      endereco_q [NUM_NA];
   logic [ADDR_WIDTH-1:0]      endereco_d [NUM_NA];
   logic [DISTANCIA_WIDTH-1:0] distancia_q [NUM_NA];
   logic [DISTANCIA_WIDTH-1:0] distancia_d [NUM_NA];
   logic [ADDR_WIDTH-1:0]      anterior_q [NUM_NA];
   logic [ADDR_WIDTH-1:0]      anterior_d [NUM_NA];
   logic [CUSTO_WIDTH-1:0]     menor_vizinho_q [NUM_NA];
   logic [CUSTO_WIDTH-1:0]     menor_vizinho_d [NUM_NA];
   logic [NUM_NA-1:0]          aprovado_q, aprovado_d;
   logic                       pendente_q, pendente_d;
   logic                       atualizar_pend_q, atualizar_pend_d;
   logic [ADDR_WIDTH-1:0]      upd_endereco_q, upd_endereco_d;
   logic [DISTANCIA_WIDTH-1:0] upd_distancia_q, upd_distancia_d;
   logic [ADDR_WIDTH-1:0]      upd_anterior_q, upd_anterior_d;
   logic [CUSTO_WIDTH-1:0]     upd_menor_vizinho_q, upd_menor_vizinho_d;
   logic [ADDR_WIDTH-1:0]      desat_addr_q, desat_addr_d;
   logic [SW-1:0]              scan_q, scan_d;
   logic [SUMW-1:0]            limiar_q, limiar_d;
   logic                       ocupado_q, ocupado_d;
   logic                       pronto_q, pronto_d;
   logic                       vazio_q, vazio_d;
   logic                       cheio_q, cheio_d;
   logic                       overflow_q, overflow_d;

   logic                       desat_hit, upd_hit, livre_hit;
   logic [SW-1:0]              desat_idx, upd_idx, livre_idx;
   logic [SUMW-1:0]            soma;

   // One extra bit so distance + smallest outgoing cost can never wrap.
   assign soma = {1'b0, distancia_q[scan_q]} + SUMW'(menor_vizinho_q[scan_q]);

   // Descending scan so the lowest matching / free index wins.
   always_comb begin
      desat_hit = 1'b0;
      desat_idx = '0;
      upd_hit   = 1'b0;
      upd_idx   = '0;
      livre_hit = 1'b0;
      livre_idx = '0;
      for (int i = NUM_NA - 1; i >= 0; i--) begin
         if (valid_q[i] && endereco_q[i] == desat_addr_q) begin
            desat_hit = 1'b1;
            desat_idx = SW'(i);
         end
         if (valid_q[i] && endereco_q[i] == upd_endereco_q) begin
            upd_hit = 1'b1;
            upd_idx = SW'(i);
         end
         if (!valid_q[i]) begin
            livre_hit = 1'b1;
            livre_idx = SW'(i);
         end
      end
   end

   always_comb begin
      estado_d            = estado_q;
      valid_d             = valid_q;
      endereco_d          = endereco_q;
      distancia_d         = distancia_q;
      anterior_d          = anterior_q;
      menor_vizinho_d     = menor_vizinho_q;
      aprovado_d          = aprovado_q;
      pendente_d          = pendente_q | cme_avaliar_in;
      atualizar_pend_d    = atualizar_pend_q;
      upd_endereco_d      = upd_endereco_q;
      upd_distancia_d     = upd_distancia_q;
      upd_anterior_d      = upd_anterior_q;
      upd_menor_vizinho_d = upd_menor_vizinho_q;
      desat_addr_d        = desat_addr_q;
      scan_d              = scan_q;
      limiar_d            = limiar_q;
      pronto_d            = 1'b0;
      overflow_d          = overflow_q;

      case (estado_q)
         IDLE: begin
            if (lvv_desativar_in || lvv_atualizar_in) begin
               atualizar_pend_d    = lvv_atualizar_in;
               upd_endereco_d      = lvv_endereco_in;
               upd_distancia_d     = lvv_distancia_in;
               upd_anterior_d      = lvv_anterior_in;
               upd_menor_vizinho_d = lvv_menor_vizinho_in;
               desat_addr_d        = lvv_desativar_addr_in;
               estado_d            = lvv_desativar_in ? DESATIVAR : ATUALIZAR;
            end else if (pendente_q) begin
               pendente_d = cme_avaliar_in;
               scan_d     = '0;
               limiar_d   = '1;
               estado_d   = LIMIAR;
            end
         end
         DESATIVAR: begin
            if (desat_hit) begin
               valid_d[desat_idx]    = 1'b0;
               aprovado_d[desat_idx] = 1'b0;
            end
            estado_d = atualizar_pend_q ? ATUALIZAR : IDLE;
         end
         ATUALIZAR: begin
            if (upd_hit) begin
               if (upd_distancia_q < distancia_q[upd_idx]) begin
                  distancia_d[upd_idx]     = upd_distancia_q;
                  anterior_d[upd_idx]      = upd_anterior_q;
                  menor_vizinho_d[upd_idx] = upd_menor_vizinho_q;
               end
            end else if (livre_hit) begin
               valid_d[livre_idx]         = 1'b1;
               endereco_d[livre_idx]      = upd_endereco_q;
               distancia_d[livre_idx]     = upd_distancia_q;
               anterior_d[livre_idx]      = upd_anterior_q;
               menor_vizinho_d[livre_idx] = upd_menor_vizinho_q;
            end else begin
               overflow_d = 1'b1;
            end
            estado_d = IDLE;
         end
         LIMIAR: begin
            if (valid_q[scan_q] && soma < limiar_q) begin
               limiar_d = soma;
            end
            if (scan_q == SW'(NUM_NA - 1)) begin
               estado_d = MARCAR;
            end else begin
               scan_d = scan_q + SW'(1);
            end
         end
         MARCAR: begin
            for (int i = 0; i < NUM_NA; i++) begin
               aprovado_d[i] = valid_q[i] && ({1'b0, distancia_q[i]} <= limiar_q);
            end
            pronto_d = 1'b1;
            estado_d = PRONTO;
         end
         PRONTO: begin
            estado_d = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase

      ocupado_d = (estado_d != IDLE);
      vazio_d   = ~|valid_d;
      cheio_d   = &valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q            <= IDLE;
         valid_q             <= '0;
         for (int i = 0; i < NUM_NA; i++) begin
            endereco_q[i]      <= '0;
            distancia_q[i]     <= '0;
            anterior_q[i]      <= '0;
            menor_vizinho_q[i] <= '0;
         end
         aprovado_q          <= '0;
         pendente_q          <= 1'b0;
         atualizar_pend_q    <= 1'b0;
         upd_endereco_q      <= '0;
         upd_distancia_q     <= '0;
         upd_anterior_q      <= '0;
         upd_menor_vizinho_q <= '0;
         desat_addr_q        <= '0;
         scan_q              <= '0;
         limiar_q            <= '1;
         ocupado_q           <= 1'b0;
         pronto_q            <= 1'b0;
         vazio_q             <= 1'b1;
         cheio_q             <= 1'b0;
         overflow_q          <= 1'b0;
      end else begin
         estado_q            <= estado_d;
         valid_q             <= valid_d;
         endereco_q          <= endereco_d;
         distancia_q         <= distancia_d;
         anterior_q          <= anterior_d;
         menor_vizinho_q     <= menor_vizinho_d;
         aprovado_q          <= aprovado_d;
         pendente_q          <= pendente_d;
         atualizar_pend_q    <= atualizar_pend_d;
         upd_endereco_q      <= upd_endereco_d;
         upd_distancia_q     <= upd_distancia_d;
         upd_anterior_q      <= upd_anterior_d;
         upd_menor_vizinho_q <= upd_menor_vizinho_d;
         desat_addr_q        <= desat_addr_d;
         scan_q              <= scan_d;
         limiar_q            <= limiar_d;
         ocupado_q           <= ocupado_d;
         pronto_q            <= pronto_d;
         vazio_q             <= vazio_d;
         cheio_q             <= cheio_d;
         overflow_q          <= overflow_d;
      end
   end

   assign aa_ocupado_out  = ocupado_q;
   assign aa_pronto_out   = pronto_q;
   assign aa_aprovado_out = aprovado_q;
   assign aa_vazio_out    = vazio_q;
   assign aa_cheio_out    = cheio_q;
   assign aa_overflow_out = overflow_q;

   for (genvar g = 0; g < NUM_NA; g++) begin : g_pack
      assign aa_endereco_out[ADDR_WIDTH*g +: ADDR_WIDTH]           = endereco_q[g];
      assign aa_anterior_data_out[ADDR_WIDTH*g +: ADDR_WIDTH]      = anterior_q[g];
      assign aa_distancia_out[DISTANCIA_WIDTH*g +: DISTANCIA_WIDTH] = distancia_q[g];
   end

endmodule

// File: tb/tb_avaliador_ativos.sv
// Testbench for avaliador_ativos: a behavioural slot-table model predicts each evaluation result,
// which is queued at request time and compared when the pronto pulse appears.
module tb_avaliador_ativos;

   localparam int AW  = 10;
   localparam int DW  = 6;
   localparam int CW  = 4;
   localparam int NA  = 4;
   localparam int LAT = NA + 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               lvvAtualizar = 1'b0;
   logic [AW-1:0]      lvvEndereco = '0;
   logic [DW-1:0]      lvvDistancia = '0;
   logic [AW-1:0]      lvvAnterior = '0;
   logic [CW-1:0]      lvvMenorVizinho = '0;
   logic               lvvDesativar = 1'b0;
   logic [AW-1:0]      lvvDesativarAddr = '0;
   logic               cmeAvaliar = 1'b0;
   logic               aaOcupado, aaPronto, aaVazio, aaCheio, aaOverflow;
   logic [NA-1:0]      aaAprovado;
   logic [AW*NA-1:0]   aaEndereco, aaAnterior;
   logic [DW*NA-1:0]   aaDistancia;

   always #5 clk = ~clk;

   avaliador_ativos #(.ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .NUM_NA(NA)) dut (
      .clk(clk), .rst_n(rst_n),
      .lvv_atualizar_in(lvvAtualizar), .lvv_endereco_in(lvvEndereco),
      .lvv_distancia_in(lvvDistancia), .lvv_anterior_in(lvvAnterior),
      .lvv_menor_vizinho_in(lvvMenorVizinho), .lvv_desativar_in(lvvDesativar),
      .lvv_desativar_addr_in(lvvDesativarAddr), .cme_avaliar_in(cmeAvaliar),
      .aa_ocupado_out(aaOcupado), .aa_pronto_out(aaPronto), .aa_aprovado_out(aaAprovado),
      .aa_endereco_out(aaEndereco), .aa_anterior_data_out(aaAnterior),
      .aa_distancia_out(aaDistancia), .aa_vazio_out(aaVazio), .aa_cheio_out(aaCheio),
      .aa_overflow_out(aaOverflow)
   );

   typedef struct {
      logic [NA-1:0] apr;
      int            reqCycle;
      bit            chkLat;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   checks = 0;
   int   errors = 0;
   int   cycleCount = 0;

   bit            mValid [NA];
   logic [AW-1:0] mAddr [NA];
   logic [DW-1:0] mDist [NA];
   logic [AW-1:0] mAnt [NA];
   logic [CW-1:0] mMv [NA];
   logic [NA-1:0] mApr;
   bit            mOvf;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Any pronto pulse must match the oldest queued evaluation.
   always @(negedge clk) begin
      if (rst_n && aaPronto === 1'b1) begin
         checkOutput("pronto_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            got = sb.pop_front();
            checkOutput("aprovado", aaAprovado, got.apr);
            if (got.chkLat) checkOutput("latency", cycleCount - got.reqCycle, LAT);
         end
      end
   end

   task automatic modelReset();
      for (int i = 0; i < NA; i++) begin
         mValid[i] = 0; mAddr[i] = '0; mDist[i] = '0; mAnt[i] = '0; mMv[i] = '0;
      end
      mApr = '0;
      mOvf = 0;
   endtask

   task automatic modelDeactivate(input logic [AW-1:0] a);
      for (int i = 0; i < NA; i++) begin
         if (mValid[i] && mAddr[i] == a) begin
            mValid[i] = 0;
            mApr[i]   = 1'b0;
            break;
         end
      end
   endtask

   task automatic modelUpdate(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [AW-1:0] p, input logic [CW-1:0] mv);
      int hit = -1;
      int free = -1;
      for (int i = NA - 1; i >= 0; i--) begin
         if (mValid[i] && mAddr[i] == a) hit = i;
         if (!mValid[i]) free = i;
      end
      if (hit >= 0) begin
         if (d < mDist[hit]) begin
            mDist[hit] = d; mAnt[hit] = p; mMv[hit] = mv;
         end
      end else if (free >= 0) begin
         mValid[free] = 1; mAddr[free] = a; mDist[free] = d; mAnt[free] = p; mMv[free] = mv;
      end else begin
         mOvf = 1;
      end
   endtask

   task automatic modelEval(output logic [NA-1:0] apr);
      int lim = (1 << (DW + 1)) - 1;
      for (int i = 0; i < NA; i++)
         if (mValid[i] && (int'(mDist[i]) + int'(mMv[i])) < lim) lim = int'(mDist[i]) + int'(mMv[i]);
      for (int i = 0; i < NA; i++) mApr[i] = mValid[i] && (int'(mDist[i]) <= lim);
      apr = mApr;
   endtask

   task automatic clearInputs();
      lvvAtualizar = 1'b0; lvvDesativar = 1'b0; cmeAvaliar = 1'b0;
   endtask

   task automatic waitIdle(output int busy);
      bit done = 0;
      busy = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         if (aaOcupado) busy++;
         if (!aaOcupado && sb.size() == 0) done = 1;
         else @(negedge clk);
      end
      checkOutput("idle_reached", done, 1);
      if (!done) sb.delete();
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      clearInputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      sb.delete();
   endtask

   // Drives one request cycle, mirrors it in the model and waits until the block settles.
   task automatic applyStimulus(input bit atu, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [AW-1:0] p, input logic [CW-1:0] mv,
                                input bit des, input logic [AW-1:0] da, input bit aval,
                                output int busy);
      exp_t ne;
      @(negedge clk);
      lvvAtualizar = atu; lvvEndereco = a; lvvDistancia = d; lvvAnterior = p;
      lvvMenorVizinho = mv; lvvDesativar = des; lvvDesativarAddr = da; cmeAvaliar = aval;
      if (des) modelDeactivate(da);
      if (atu) modelUpdate(a, d, p, mv);
      if (aval) begin
         modelEval(ne.apr);
         ne.reqCycle = cycleCount;
         ne.chkLat   = !(atu || des);
         sb.push_back(ne);
      end
      @(negedge clk);
      clearInputs();
      waitIdle(busy);
   endtask

   task automatic checkSlots(input string tag);
      for (int i = 0; i < NA; i++) begin
         if (mValid[i]) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), aaEndereco[AW*i +: AW], mAddr[i]);
            checkOutput($sformatf("%s_dist%0d", tag, i), aaDistancia[DW*i +: DW], mDist[i]);
            checkOutput($sformatf("%s_ant%0d", tag, i), aaAnterior[AW*i +: AW], mAnt[i]);
         end
      end
      checkOutput({tag, "_vazio"}, aaVazio, mValid.sum() with (int'(item)) == 0);
      checkOutput({tag, "_cheio"}, aaCheio, mValid.sum() with (int'(item)) == NA);
      checkOutput({tag, "_overflow"}, aaOverflow, mOvf);
      checkOutput({tag, "_aprovado"}, aaAprovado, mApr);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ocupado"}, aaOcupado, 0);
      checkOutput({tag, "_pronto"}, aaPronto, 0);
      checkOutput({tag, "_vazio"}, aaVazio, 1);
      checkOutput({tag, "_cheio"}, aaCheio, 0);
      checkOutput({tag, "_overflow"}, aaOverflow, 0);
      checkOutput({tag, "_aprovado"}, aaAprovado, 0);
      checkOutput({tag, "_endereco"}, aaEndereco, 0);
      checkOutput({tag, "_distancia"}, aaDistancia, 0);
      checkOutput({tag, "_anterior"}, aaAnterior, 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int b;
      exp_t ne;
      modelReset();
      applyReset();
      @(negedge clk);
      checkResetState("reset");

      // Single node, evaluation latency
      applyStimulus(1, 5, 0, 5, 2, 0, 0, 0, b);
      checkOutput("upd_busy", b, 1);
      checkSlots("ins5");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);
      checkOutput("eval1_apr", aaAprovado, 4'b0001);

      // Three nodes, threshold 7
      applyReset();
      applyStimulus(1, 10, 3, 1, 4, 0, 0, 0, b);
      applyStimulus(1, 11, 6, 1, 1, 0, 0, 0, b);
      applyStimulus(1, 12, 9, 1, 1, 0, 0, 0, b);
      checkSlots("three");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);
      checkOutput("eval3_apr", aaAprovado, 4'b0011);

      // Relaxation: larger and equal distances ignored, smaller accepted
      applyStimulus(1, 11, 8, 9, 3, 0, 0, 0, b);
      checkSlots("upd_gt");
      applyStimulus(1, 11, 6, 9, 3, 0, 0, 0, b);
      checkSlots("upd_eq");
      applyStimulus(1, 11, 2, 7, 1, 0, 0, 0, b);
      checkOutput("slot1_dist", aaDistancia[DW*1 +: DW], 2);
      checkOutput("slot1_ant", aaAnterior[AW*1 +: AW], 7);
      checkSlots("upd_lt");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);

      // Fill, overflow, free and reuse
      applyStimulus(1, 13, 1, 13, 3, 0, 0, 0, b);
      checkSlots("full");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);
      applyStimulus(1, 14, 5, 14, 9, 0, 0, 0, b);
      checkOutput("overflow_set", aaOverflow, 1);
      checkOutput("cheio_set", aaCheio, 1);
      checkSlots("drop");
      applyStimulus(0, 0, 0, 0, 0, 1, 12, 0, b);
      checkSlots("desat12");
      applyStimulus(1, 14, 5, 14, 9, 0, 0, 0, b);
      checkOutput("reuse_slot2", aaEndereco[AW*2 +: AW], 14);
      checkSlots("reuse");

      // Same-cycle deactivate and insert
      applyStimulus(1, 20, 4, 20, 0, 1, 10, 0, b);
      checkOutput("dual_busy", b, 2);
      checkOutput("reuse_slot0", aaEndereco[AW*0 +: AW], 20);
      checkSlots("dual");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);
      applyStimulus(1, 13, 0, 13, 0, 0, 0, 1, b);
      checkSlots("upd_eval");

      // Wide sums must not wrap
      applyReset();
      applyStimulus(1, 1, 63, 1, 15, 0, 0, 0, b);
      applyStimulus(1, 2, 62, 1, 15, 0, 0, 0, b);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, b);
      checkOutput("nowrap_apr", aaAprovado, 4'b0011);

      // Empty table evaluation with an update that arrives while busy
      applyReset();
      @(negedge clk);
      cmeAvaliar = 1'b1;
      ne.apr = '0; ne.reqCycle = cycleCount; ne.chkLat = 1;
      sb.push_back(ne);
      @(negedge clk);
      cmeAvaliar = 1'b0;
      @(negedge clk);
      lvvAtualizar = 1'b1; lvvEndereco = 7; lvvDistancia = 1;
      @(negedge clk);
      lvvAtualizar = 1'b0;
      waitIdle(b);
      checkSlots("ignored");

      // Reset in the middle of the threshold scan
      applyStimulus(1, 3, 1, 3, 1, 0, 0, 0, b);
      @(negedge clk);
      cmeAvaliar = 1'b1;
      @(negedge clk);
      cmeAvaliar = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("busy_in_limiar", aaOcupado, 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetState("midreset");
      rst_n = 1'b1;
      modelReset();
      repeat (12) @(negedge clk);
      checkSlots("after_midreset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
